// File: rtl/mmio_store_sink_if.sv
// mmio_store_sink_if
// Bundles the MEM-stage store port and the downstream valid/ready stream
// of the memory-mapped store sink, plus its status outputs.
//   memwrite / dataaddr / writedata : store strobe, byte address, data (core -> sink)
//   out_valid / out_data / out_ready : FIFO head stream (sink <-> consumer)
//   fifo_count / overflow / enabled / stores_seen : status (sink -> observers)
// Modports: master = core + consumer side, slave = the sink itself.
interface mmio_store_sink_if #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic          memwrite;
  logic [31:0]   dataaddr;
  logic [31:0]   writedata;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          enabled;
  logic [15:0]   stores_seen;

  modport master (
    output memwrite, dataaddr, writedata, out_ready,
    input  out_valid, out_data, fifo_count, overflow, enabled, stores_seen
  );

  modport slave (
    input  memwrite, dataaddr, writedata, out_ready,
    output out_valid, out_data, fifo_count, overflow, enabled, stores_seen
  );
endinterface

// File: rtl/mmio_store_sink.sv
// mmio_store_sink
// Memory-mapped store responder beside data memory. Stores to BASE_ADDR
// are queued in a DEPTH-entry FIFO and drained over a valid/ready stream;
// stores to BASE_ADDR+4 write the control register (bit0 enable,
// bit1 one-shot flush that also clears the sticky overflow flag).
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mmio_store_sink_if slave modport (store port, stream, status)
module mmio_store_sink #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 4,
  parameter int          CW        = $clog2(DEPTH) + 1
) (
  input logic               clk,
  input logic               reset,
  mmio_store_sink_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic          overflowReg;
  logic          enabledReg;
  logic [15:0]   storesSeen;

  logic dataHit;
  logic ctrlHit;
  logic flush;
  logic isFull;
  logic headValid;
  logic pop;
  logic push;
  logic drop;

  // Exact 32-bit decode; the registered enable gates data stores, so a
  // control write only affects stores from the following cycle onward.
  always_comb begin
    dataHit   = bus.memwrite && (bus.dataaddr == BASE_ADDR);
    ctrlHit   = bus.memwrite && (bus.dataaddr == CTRL_ADDR);
    flush     = ctrlHit && bus.writedata[1];
    isFull    = (count == FULL_COUNT);
    headValid = (count != '0);
    pop       = headValid && bus.out_ready;
    push      = dataHit && enabledReg && (!isFull || pop);
    drop      = dataHit && enabledReg && isFull && !pop;
  end

  // Storage array has no reset so it can map onto RAM; validity is tracked
  // by count alone. A push into a full FIFO only happens alongside a pop,
  // so the overwritten slot is the one leaving at the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= bus.writedata;
    end
  end

  // Pointer, occupancy and status state. Flush and a data push can never
  // coincide because they decode different addresses; flush beats a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflowReg <= 1'b0;
      enabledReg  <= 1'b0;
      storesSeen  <= '0;
    end else begin
      if (ctrlHit) begin
        enabledReg <= bus.writedata[0];
      end
      if (flush) begin
        wrPtr       <= '0;
        rdPtr       <= '0;
        count       <= '0;
        overflowReg <= 1'b0;
      end else begin
        if (push) begin
          wrPtr <= wrPtr + 1'b1;
        end
        if (pop) begin
          rdPtr <= rdPtr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
        if (drop) begin
          overflowReg <= 1'b1;
        end
      end
      if (push) begin
        storesSeen <= storesSeen + 16'd1;
      end
    end
  end

  // Head word is forced to zero while empty so the stream never shows
  // stale data after reset, flush or drain.
  assign bus.out_valid   = headValid;
  assign bus.out_data    = headValid ? mem[rdPtr] : 32'd0;
  assign bus.fifo_count  = count;
  assign bus.overflow    = overflowReg;
  assign bus.enabled     = enabledReg;
  assign bus.stores_seen = storesSeen;
endmodule

// File: doc/mmio_store_sink.md
# mmio_store_sink

Memory-mapped store responder attached to the pipelined core's data-store port (`memwrite`, `dataaddr`, `writedata`).
- Decodes stores to two word addresses: a data register and a control register.
- Queues accepted data words in a small FIFO.
- Drains the FIFO to a downstream consumer over a valid/ready stream.
- Sits beside data memory and is driven by the same MEM-stage store signals, so software can emit words for a debug console, test harness or UART front-end.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_0000: data register address; control register is `BASE_ADDR+4`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CW`, default `$clog2(DEPTH)+1`: width of `fifo_count`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  store strobe from the MEM stage.
- `dataaddr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `out_valid`  out  1  FIFO head valid.
- `out_data`  out  32  FIFO head word.
- `out_ready`  in  1  consumer accepts head.
- `fifo_count`  out  CW  occupied entries, 0..DEPTH.
- `overflow`  out  1  sticky; a data store was dropped because the FIFO was full.
- `enabled`  out  1  control bit 0.
- `stores_seen`  out  16  count of accepted data stores; wraps.

## Operation
- Address decode is an exact 32-bit compare, so unaligned or other addresses are ignored entirely.
  - Data hit: `memwrite && dataaddr==BASE_ADDR`.
  - Control hit: `memwrite && dataaddr==BASE_ADDR+4`.
- Control write effects:
  - `enabled <= writedata[0]`.
  - If `writedata[1]` is 1: flush the FIFO (count→0, `out_valid`→0) and clear `overflow`. This bit is self-clearing and has no storage.
  - `writedata[31:2]` are ignored.
- Data hit handling:
  - `enabled==0`: store ignored. No push, no count, no overflow.
  - `enabled==1` and (not full, or pop in the same cycle): push `writedata` at the tail and increment `stores_seen`.
  - `enabled==1`, full and no pop: word dropped, `overflow<=1`, `stores_seen` unchanged.
- Pop occurs when `out_valid && out_ready`; the head advances.
- Simultaneous push and pop: `fifo_count` is unchanged and both take effect.
- Push into an empty FIFO with `out_ready=1` is not bypassed; the word appears at the head the next cycle.
- Control flush in the same cycle as a pop: flush wins.
- Pointers wrap modulo `DEPTH`. Full when count==DEPTH; empty when count==0.
- `stores_seen` wraps 16'hFFFF→0.
- FIFO order is strict: first in, first out.

## Timing
- Reset, synchronous and sampled on `clk` rise: pointers and count 0, `out_valid`=0, `out_data`=0, `overflow`=0, `enabled`=0, `stores_seen`=0. Reset mid-stream discards all queued words.
- Push latency: store sampled at edge N → `out_valid`=1 and `out_data`=word after edge N (visible in cycle N+1).
- All outputs are registered or derived from registered state. No combinational path from `memwrite`/`dataaddr`/`writedata` to any output.
- `out_data` holds stable while `out_valid && !out_ready`. `out_valid` never drops without a pop, flush or reset.
- `fifo_count`, `overflow` and `enabled` update at the same edge as the causing store.
- The consumer may hold `out_ready` high continuously. Sustained throughput is 1 word/cycle.
- `out_ready` while `out_valid==0` has no effect.

## Test plan
- Reset, then a data store of 32'hDEAD_BEEF before any enable → `out_valid`=0, `stores_seen`=0, `fifo_count`=0. Then a control write of 1, then data stores 0x11, 0x22 with `out_ready`=0 → `fifo_count`=2, `out_data`=0x11 held; then raise `out_ready` → 0x11, 0x22 emitted on consecutive cycles, `stores_seen`=2.
- Fill with DEPTH=4: enable, 5 data stores 1..5 with `out_ready`=0 → `fifo_count`=4, `overflow`=1, `stores_seen`=4; drain yields 1,2,3,4 only.
- Full FIFO, data store 9 in the same cycle as a pop → accepted, `fifo_count` stays 4, `overflow` unchanged; drain order ends with …,9.
- Control write 32'h3 while 3 words are queued and `out_ready`=1 → next cycle `fifo_count`=0, `out_valid`=0, `overflow`=0, `enabled`=1. Then stores to `BASE_ADDR+1` and `BASE_ADDR+8` → ignored.
- Assert `reset` for one cycle with 2 words queued and `stores_seen`=16'hFFFF → all outputs return to 0. Separately, starting from `stores_seen`=16'hFFFF, one accepted push → `stores_seen`=0.
